pmem_arbiter: RTL and testbench

Arbitrates one physical-memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs). It sits between the two cache instances and the single pmem/cacheline-adapter interface. Requests are latched at grant, so the pmem side sees stable address, data and command for the whole transaction. The response is routed only to the owning cache.

---
 rtl/arb_types_pkg.sv | 26 ++
 rtl/arb_grant_logic.sv | 52 +++++
 rtl/pmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_pmem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_types_pkg.sv
// Shared types and defaults for the pmem arbiter: FSM states, grant owner,
// default widths and the streak-counter width helper.
package arb_types_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BUSY  = 2'd1,
        D_BUSY  = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Bits needed to hold 0..limit inclusive.
    function automatic int streak_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_grant_logic.sv
// Grant selection between instruction and data requests, with the data-side
// streak counter that bounds how long a pending instruction fill can wait.
module arb_grant_logic
    import arb_types_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle,
    input  logic       i_read,
    input  logic       d_req,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    localparam int STREAK_W = streak_width(STARVE_LIMIT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] d_streak_reg;
    logic [STREAK_W-1:0] d_streak_next;

    always_comb begin
        grant_valid = idle && (i_read || d_req);
        grant_owner = OWN_I;
        // Data normally wins; once it has won STARVE_LIMIT times in a row
        // over a waiting instruction fill, the instruction side goes next.
        if (d_req && !(i_read && (d_streak_reg == STREAK_MAX))) begin
            grant_owner = OWN_D;
        end
    end

    always_comb begin
        d_streak_next = d_streak_reg;
        if (idle) begin
            if (!i_read || (grant_owner == OWN_I)) begin
                d_streak_next = '0;
            end else if (d_streak_reg != STREAK_MAX) begin
                d_streak_next = d_streak_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_streak_reg <= '0;
        end else begin
            d_streak_reg <= d_streak_next;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache.
// Optional grant/conflict counters are enabled with `define ARB_PERF_CNT_EN.
module pmem_arbiter
    import arb_types_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int LINE_W       = ARB_LINE_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
`endif
);

    arb_state_t        state_reg, state_next;
    arb_owner_t        grant_owner;
    logic              grant_valid;
    logic              d_req;
    logic              idle;
    logic              busy;
    logic              grant_fire;
    logic              pmem_read_reg, pmem_write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] wdata_reg;

    assign d_req      = d_read || d_write;
    assign idle       = (state_reg == IDLE);
    assign busy       = (state_reg == I_BUSY) || (state_reg == D_BUSY);
    assign grant_fire = idle && grant_valid;

    arb_grant_logic #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .idle       (idle),
        .i_read     (i_read),
        .d_req      (d_req),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_owner == OWN_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command, address and data are captured at grant so the memory side
    // sees them stable even if the cache changes its inputs afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else if (grant_fire) begin
            if (grant_owner == OWN_D) begin
                pmem_read_reg  <= !d_write;
                pmem_write_reg <= d_write;
                addr_reg       <= d_addr;
                wdata_reg      <= d_wdata;
            end else begin
                pmem_read_reg  <= 1'b1;
                pmem_write_reg <= 1'b0;
                addr_reg       <= i_addr;
            end
        end else if (busy && pmem_resp) begin
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
        end
    end

    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_address = addr_reg;
    assign pmem_wdata   = wdata_reg;

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign i_resp  = (state_reg == I_BUSY) && pmem_resp;
    assign d_resp  = (state_reg == D_BUSY) && pmem_resp;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_reg, perf_d_reg, perf_c_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_reg <= '0;
            perf_d_reg <= '0;
            perf_c_reg <= '0;
        end else if (grant_fire) begin
            if (grant_owner == OWN_D) begin
                perf_d_reg <= perf_d_reg + 32'd1;
            end else begin
                perf_i_reg <= perf_i_reg + 32'd1;
            end
            if (i_read && d_req) begin
                perf_c_reg <= perf_c_reg + 32'd1;
            end
        end
    end

    assign perf_i_grants  = perf_i_reg;
    assign perf_d_grants  = perf_d_reg;
    assign perf_conflicts = perf_c_reg;
`endif

    a_no_read_and_write: assert property (
        @(posedge clk) disable iff (!rst_n) !(d_read && d_write));

    a_resp_only_when_busy: assert property (
        @(posedge clk) disable iff (!rst_n) pmem_resp |-> busy);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomised scoreboard bench for pmem_arbiter with a timeline-based model of
// port availability and the starvation rule.
module tb_pmem_arbiter;

    localparam int LIMIT = 4;

    typedef struct {
        int           cyc;
        bit           own_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } gexp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, pmem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, pmem_rdata;
    logic [255:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]  perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    int checks = 0;
    int failures = 0;

    gexp_t grant_q[$];
    bit    resp_q[$];
    bit    resp_log[$];
    int    cyc = 0;
    int    mem_lat = 0;
    bit    i_granted = 0;
    bit    d_granted = 0;
    int    m_i = 0, m_d = 0, m_c = 0;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: the port is free again two edges after the edge that
    // sees the memory response; data wins ties until it has won LIMIT times
    // in a row with an instruction fill waiting.
    initial begin : model
        bit busy = 0;
        int free_at = 0;
        int streak = 0;
        bit dreq, take_d;
        gexp_t g;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy = 0; free_at = 0; streak = 0;
                grant_q.delete(); resp_q.delete();
                i_granted = 0; d_granted = 0;
                m_i = 0; m_d = 0; m_c = 0;
            end else if (clk) begin
                cyc++;
                dreq = d_read || d_write;
                if (busy) begin
                    if (pmem_resp) begin
                        busy = 0; free_at = cyc + 2;
                        i_granted = 0; d_granted = 0;
                    end
                end else if (cyc >= free_at) begin
                    if (i_read || dreq) begin
                        take_d = dreq && !(i_read && streak == LIMIT);
                        g.cyc = cyc; g.own_d = take_d; g.wr = take_d && d_write;
                        g.addr = take_d ? d_addr : i_addr; g.wdata = d_wdata;
                        grant_q.push_back(g); resp_q.push_back(take_d);
                        busy = 1;
                        if (i_read && dreq) m_c++;
                        if (take_d) begin
                            d_granted = 1; m_d++;
                            streak = i_read ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
                        end else begin
                            i_granted = 1; m_i++;
                            streak = 0;
                        end
                    end else begin
                        streak = 0;
                    end
                end
            end
        end
    end

    // Memory: responds mem_lat cycles (random 1..6 when 0) after a command appears.
    initial begin : memory
        int cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    pmem_resp = 1'b1;
                    pmem_rdata = rand256();
                end
            end else if (pmem_read || pmem_write) begin
                cnt = (mem_lat > 0) ? mem_lat : $urandom_range(1, 6);
            end
        end
    end

    // Monitor: pops grant and response expectations as the DUT presents them.
    initial begin : monitor
        bit cmd, prev_cmd = 0, o;
        gexp_t e, cur;
        cur = '{0, 0, 0, '0, '0};
        forever begin
            @(negedge clk);
            cmd = pmem_read || pmem_write;
            if (cmd && !prev_cmd) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    e = grant_q.pop_front();
                    chk("grant_cycle", 256'(cyc), 256'(e.cyc));
                    chk("grant_write", pmem_write, e.wr);
                    chk("grant_read", pmem_read, !e.wr);
                    chk("grant_addr", pmem_address, e.addr);
                    if (e.wr) chk("grant_wdata", pmem_wdata, e.wdata);
                    cur = e;
                end
            end else if (cmd) begin
                chk("hold_addr", pmem_address, cur.addr);
                chk("hold_write", pmem_write, cur.wr);
                if (cur.wr) chk("hold_wdata", pmem_wdata, cur.wdata);
            end else if (grant_q.size() > 0 && grant_q[0].cyc <= cyc) begin
                e = grant_q.pop_front();
                chk("missed_grant", 1'b0, 1'b1);
            end
            prev_cmd = cmd;

            if (i_resp || d_resp) begin
                chk("resp_one_hot", i_resp && d_resp, 1'b0);
                chk("resp_with_pmem_resp", pmem_resp, 1'b1);
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    o = resp_q.pop_front();
                    chk("resp_owner_d", d_resp, o);
                    chk("resp_data", d_resp ? d_rdata : i_rdata, pmem_rdata);
                    resp_log.push_back(d_resp);
                end
            end else if (pmem_resp && resp_q.size() > 0) begin
                o = resp_q.pop_front();
                chk("missed_resp", 1'b0, 1'b1);
            end
        end
    end

    task automatic do_i(input logic [31:0] a);
        bit done = 0;
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = a;
        for (int k = 0; k < 300 && !done; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (i_granted) i_addr = $urandom;
            @(negedge clk);
            done = i_resp;
        end
        chk("i_resp_seen", done, 1'b1);
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic do_d(input bit wr, input logic [31:0] a, input logic [255:0] wd);
        bit done = 0;
        @(posedge clk); #1;
        d_read = !wr; d_write = wr; d_addr = a; d_wdata = wd;
        for (int k = 0; k < 300 && !done; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (d_granted) begin
                d_addr = $urandom; d_wdata = rand256();
            end
            @(negedge clk);
            done = d_resp;
        end
        chk("d_resp_seen", done, 1'b1);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit exp_starve[6] = '{1, 1, 1, 1, 0, 1};
`ifdef ARB_PERF_CNT_EN
        logic [31:0] pi, pd, pc;
`endif
        rst_n = 1'b0;
        i_read = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_pmem_read", pmem_read, 1'b0);
            chk("rst_pmem_write", pmem_write, 1'b0);
            chk("rst_i_resp", i_resp, 1'b0);
            chk("rst_d_resp", d_resp, 1'b0);
            chk("rst_pmem_address", pmem_address, 32'h0);
            chk("rst_pmem_wdata", pmem_wdata, 256'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single instruction read, memory answers after 5 cycles.
        mem_lat = 5;
        resp_log.delete();
        do_i(32'h0000_0060);
        chk("single_i_count", 256'(resp_log.size()), 256'd1);
        if (resp_log.size() == 1) chk("single_i_owner", resp_log[0], 1'b0);

        // Single data write-back.
        mem_lat = 3;
        resp_log.delete();
        do_d(1'b1, 32'h8000_0020, {8{32'hB5B5_A0A0}});
        chk("single_d_count", 256'(resp_log.size()), 256'd1);

        // Simultaneous requests: data first, then instruction.
`ifdef ARB_PERF_CNT_EN
        pi = perf_i_grants; pd = perf_d_grants; pc = perf_conflicts;
`endif
        mem_lat = 2;
        resp_log.delete();
        fork
            do_i(32'h0000_0100);
            do_d(1'b0, 32'h0000_0200, '0);
        join
        chk("simul_count", 256'(resp_log.size()), 256'd2);
        if (resp_log.size() == 2) begin
            chk("simul_first_d", resp_log[0], 1'b1);
            chk("simul_second_i", resp_log[1], 1'b0);
        end
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_delta", perf_i_grants - pi, 32'd1);
        chk("perf_d_delta", perf_d_grants - pd, 32'd1);
        chk("perf_c_delta", perf_conflicts - pc, 32'd1);
`endif

        // Starvation bound: D D D D I D.
        mem_lat = 0;
        resp_log.delete();
        fork
            begin
                repeat (5) do_d(1'b0, $urandom, '0);
            end
            do_i(32'h0000_0400);
        join
        chk("starve_count", 256'(resp_log.size()), 256'd6);
        if (resp_log.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("starve_order_%0d", k), resp_log[k], exp_starve[k]);
        end

        // Reset while the data write is outstanding.
        mem_lat = 50;
        @(posedge clk); #1;
        d_write = 1'b1; d_addr = 32'h0000_0800; d_wdata = rand256();
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_write", pmem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_write", pmem_write, 1'b0);
        chk("async_rst_d_resp", d_resp, 1'b0);
        d_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_lat = 3;
        resp_log.delete();
        do_d(1'b1, 32'h0000_0840, rand256());
        chk("post_reset_count", 256'(resp_log.size()), 256'd1);

        // Randomised traffic from both caches.
        mem_lat = 0;
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_i($urandom);
            end
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_d(1'($urandom_range(0, 1)), $urandom, rand256());
            end
        join

        repeat (4) @(negedge clk);
        chk("grant_q_empty", 256'(grant_q.size()), 256'd0);
        chk("resp_q_empty", 256'(resp_q.size()), 256'd0);
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_total", perf_i_grants, 32'(m_i));
        chk("perf_d_total", perf_d_grants, 32'(m_d));
        chk("perf_c_total", perf_conflicts, 32'(m_c));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
